expand3_mac_array: RTL

Convolution engine for the fire expand3x3 layer. Drives the address of the per-output-channel weight ROM array and consumes its NUM parallel weight words. Accepts a stream of DEPTH input activations (one 3x3xCIN window, KERNEL*KERNEL*CIN words) and multiply-accumulates each against the matching weight of every output channel. Emits NUM ReLU'd, saturated output pixels through a valid/ready handshake.

---
 rtl/expand3_mac_array.sv | 107 ++++++++++
 1 files changed

// File: rtl/expand3_mac_array.sv
// expand3x3 MAC array: one activation per cycle against NUM weight lanes, ReLU+saturate on output.
// Latency: last activation accept -> out_valid two edges later; one window in flight at a time.
// Backpressure: act_ready only in RUN; out_data/out_valid held in OUT until out_ready.
module expand3_mac_array #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8,
    parameter int ADDR  = 8,
    parameter int NUM   = 64,
    parameter int DEPTH = 144,
    parameter int ACC_W = 2*WIDTH+8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          act_valid,
    input  logic [WIDTH-1:0]              act_in,
    output logic                          act_ready,
    output logic [ADDR-1:0]               rom_addr,
    input  logic [0:NUM-1][WIDTH-1:0]     rom_out,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [0:NUM-1][WIDTH-1:0]     out_data,
    output logic                          busy
);

    typedef enum logic [2:0] {IDLE, RUN, ACC, LOAD, OUT} state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2**(WIDTH-1)) - 1);

    state_t state, state_nxt;
    logic   accept;
    logic   last;
    logic   prod_v;
    logic signed [2*WIDTH-1:0] prod [NUM];
    logic signed [ACC_W-1:0]   acc  [NUM];

    assign act_ready = (state == RUN);
    assign busy      = (state != IDLE);
    assign accept    = act_valid & act_ready;
    assign last      = (rom_addr == ADDR'(DEPTH-1));

    // Floor shift, then clamp to [0, max positive].
    function automatic logic [WIDTH-1:0] relu_sat(input logic signed [ACC_W-1:0] x);
        logic signed [ACC_W-1:0] s;
        s = x >>> FRAC;
        if (s < 0)
            return '0;
        else if (s > SAT_MAX)
            return SAT_MAX[WIDTH-1:0];
        else
            return s[WIDTH-1:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN:  if (accept && last) state_nxt = ACC;
            ACC:  state_nxt = LOAD;
            LOAD: state_nxt = OUT;
            OUT:  if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr  <= '0;
            prod_v    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < NUM; i++) begin
                prod[i] <= '0;
                acc[i]  <= '0;
            end
        end else begin
            prod_v <= accept;
            if (accept)
                rom_addr <= last ? '0 : rom_addr + ADDR'(1);

            for (int i = 0; i < NUM; i++) begin
                if (accept)
                    prod[i] <= $signed(act_in) * $signed(rom_out[i]);
                // prod_v is never set while IDLE, so clear and accumulate cannot collide.
                if (state == IDLE && start)
                    acc[i] <= '0;
                else if (prod_v)
                    acc[i] <= acc[i] + {{(ACC_W-2*WIDTH){prod[i][2*WIDTH-1]}}, prod[i]};
                if (state == LOAD)
                    out_data[i] <= relu_sat(acc[i]);
            end

            if (state == LOAD)
                out_valid <= 1'b1;
            else if (state == OUT && out_ready)
                out_valid <= 1'b0;
        end
    end

endmodule
